// File: rtl/apb3_lcd_regbank_if.sv
// apb3_lcd_regbank_if: APB3 bus bundle between the CPU master and the LCD register bank
interface apb3_lcd_regbank_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic PSEL;
  logic PENABLE;
  logic PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic PSLVERROR;
  modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PREADY, PRDATA, PSLVERROR);
  modport slave (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PREADY, PRDATA, PSLVERROR);
endinterface

// File: rtl/apb3_lcd_regbank.sv
// apb3_lcd_regbank: APB3 double-buffered LCD channel registers with atomic commit and timed strobe
module apb3_lcd_regbank #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH = 4,
  parameter int CH_WIDTH = 20,
  parameter int STB_CYCLES = 4
) (
  input logic clk,
  input logic resetn,
  apb3_lcd_regbank_if.slave apb,
  output logic [NUM_CH*CH_WIDTH-1:0] LCD_DATA,
  output logic LCD_STB,
  output logic LCD_BUSY
);
  localparam int CW = $clog2(STB_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [CH_WIDTH-1:0] shadow [NUM_CH];
  logic [CH_WIDTH-1:0] shadow_d [NUM_CH];
  logic [CH_WIDTH-1:0] active [NUM_CH];
  logic [CH_WIDTH-1:0] sh_rd, act_rd;
  logic [3:0] sel;
  logic auto, pending, err_q;
  logic [7:0] count;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] prdata, rdata;
  logic [7:0] a;
  logic [3:0] idx;
  logic is_ch, is_ctrl, is_stat, is_sel, is_act, act_ok, rd_err, wr, commit, exec;
  logic unused;
  assign unused = ^{apb.PADDR, apb.PWDATA};
  assign a = apb.PADDR[7:0];
  assign idx = a[5:2];
  assign is_ch = a[7:6] == 2'b00 && a[1:0] == 2'b00 && {1'b0, idx} < 5'(NUM_CH);
  assign is_ctrl = a == 8'h40;
  assign is_stat = a == 8'h44;
  assign is_sel = a == 8'h48;
  assign is_act = a == 8'h4C;
  assign act_ok = {1'b0, sel} < 5'(NUM_CH);
  assign rd_err = !(is_ch || is_ctrl || is_sel || (!apb.PWRITE && (is_stat || (is_act && act_ok))));
  // err_q was resolved in WAIT, so a rejected access never reaches any register
  assign wr = state == RESP && apb.PSEL && apb.PWRITE && !err_q;
  assign commit = wr && ((is_ctrl && apb.PWDATA[0]) || (auto && is_ch && idx == 4'(NUM_CH - 1)));
  assign LCD_STB = cnt != '0;
  assign LCD_BUSY = LCD_STB || pending;
  assign exec = (commit && !LCD_BUSY) || (pending && !LCD_STB);
  assign apb.PREADY = state == RESP;
  assign apb.PRDATA = prdata;
  assign apb.PSLVERROR = state == RESP && err_q;
  assign rdata = is_ch ? DATA_WIDTH'(sh_rd) : is_ctrl ? DATA_WIDTH'({auto, 1'b0}) :
                 is_stat ? DATA_WIDTH'({count, 6'b0, pending, LCD_BUSY}) :
                 is_sel ? DATA_WIDTH'(sel) : DATA_WIDTH'(act_rd);
  always_comb begin
    state_n = state == IDLE ? (apb.PSEL && apb.PENABLE ? WAIT : IDLE) :
              state == WAIT ? (apb.PSEL ? RESP : IDLE) : IDLE;
  end
  // shadow_d lets a commit on the same write capture that write's data
  always_comb begin
    sh_rd = '0;
    act_rd = '0;
    shadow_d = shadow;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == 4'(i)) sh_rd = shadow[i];
      if (sel == 4'(i)) act_rd = active[i];
      if (wr && is_ch && idx == 4'(i)) shadow_d[i] = apb.PWDATA[CH_WIDTH-1:0];
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      shadow <= '{default: '0};
      active <= '{default: '0};
      sel <= '0;
      auto <= 1'b0;
      pending <= 1'b0;
      count <= '0;
      cnt <= '0;
      prdata <= '0;
      err_q <= 1'b0;
    end else begin
      shadow <= shadow_d;
      if (state == WAIT && apb.PSEL) begin
        prdata <= rd_err ? '0 : rdata;
        err_q <= rd_err;
      end
      if (wr && is_ctrl) auto <= apb.PWDATA[1];
      if (wr && is_sel) sel <= apb.PWDATA[3:0];
      if (exec) begin
        active <= shadow_d;
        count <= count + 8'd1;
        cnt <= CW'(STB_CYCLES);
      end else if (LCD_STB) cnt <= cnt - CW'(1);
      pending <= LCD_STB && (pending || commit);
    end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lcd
    assign LCD_DATA[k*CH_WIDTH +: CH_WIDTH] = active[k];
  end
endmodule

// File: tb/tb_apb3_lcd_regbank.sv
// tb_apb3_lcd_regbank: directed vector tables plus commit/strobe/reset sequences for the LCD register bank
module tb_apb3_lcd_regbank;
  localparam int AW = 16, DW = 32, NCH = 4, CHW = 20, STB = 12;
  typedef struct packed {
    logic [7:0] addr;
    logic wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NCH*CHW-1:0] lcd_data;
  logic lcd_stb, lcd_busy;
  logic [63:0] stb_h, busy_h;
  logic [31:0] rd;
  logic er;
  int tests = 0, fails = 0;
  vec_t init_v [7];
  vec_t err_v [17];
  always #5 clk = ~clk;
  apb3_lcd_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  apb3_lcd_regbank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH), .CH_WIDTH(CHW), .STB_CYCLES(STB)) dut (
    .clk(clk), .resetn(resetn), .apb(bus), .LCD_DATA(lcd_data), .LCD_STB(lcd_stb), .LCD_BUSY(lcd_busy));
  function automatic vec_t mk(input logic [7:0] a, input logic w, input logic [31:0] d, input logic [31:0] r, input logic e);
    mk = {a, w, d, r, e};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    stb_h = {stb_h[62:0], lcd_stb};
    busy_h = {busy_h[62:0], lcd_busy};
  endtask
  task automatic xfer(input logic [7:0] addr, input logic w, input logic [31:0] d, output logic [31:0] r, output logic e);
    logic [3:0] rdy;
    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR = {8'hA5, addr};
    bus.PWRITE = w;
    bus.PWDATA = d;
    tick;
    bus.PENABLE = 1'b1;
    rdy[0] = bus.PREADY;
    tick;
    rdy[1] = bus.PREADY;
    tick;
    rdy[2] = bus.PREADY;
    r = bus.PRDATA;
    e = bus.PSLVERROR;
    tick;
    rdy[3] = bus.PREADY;
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    chk($sformatf("pready_timing_%02h", addr), 128'(rdy), 128'(4'b0100));
  endtask
  task automatic run_vec(input string tag, input vec_t v);
    xfer(v.addr, v.wr, v.wdata, rd, er);
    if (!v.wr) chk($sformatf("%s_rdata_%02h", tag, v.addr), 128'(rd), 128'(v.rdata));
    chk($sformatf("%s_err_%02h_w%0d", tag, v.addr, v.wr), 128'(er), 128'(v.err));
  endtask
  task automatic apb_wr(input logic [7:0] addr, input logic [31:0] d);
    run_vec("wr", mk(addr, 1'b1, d, 32'h0, 1'b0));
  endtask
  task automatic apb_rd(input logic [7:0] addr, input logic [31:0] exp);
    run_vec("rd", mk(addr, 1'b0, 32'h0, exp, 1'b0));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end
  initial begin
    init_v[0] = mk(8'h00, 1'b0, 32'h0, 32'h0, 1'b0);
    init_v[1] = mk(8'h04, 1'b0, 32'h0, 32'h0, 1'b0);
    init_v[2] = mk(8'h08, 1'b0, 32'h0, 32'h0, 1'b0);
    init_v[3] = mk(8'h0C, 1'b0, 32'h0, 32'h0, 1'b0);
    init_v[4] = mk(8'h40, 1'b0, 32'h0, 32'h0, 1'b0);
    init_v[5] = mk(8'h44, 1'b0, 32'h0, 32'h0, 1'b0);
    init_v[6] = mk(8'h48, 1'b0, 32'h0, 32'h0, 1'b0);
    err_v[0] = mk(8'h50, 1'b0, 32'h0, 32'h0, 1'b1);
    err_v[1] = mk(8'h44, 1'b1, 32'hFFFF, 32'h0, 1'b1);
    err_v[2] = mk(8'h48, 1'b1, 32'h5, 32'h0, 1'b0);
    err_v[3] = mk(8'h48, 1'b0, 32'h0, 32'h5, 1'b0);
    err_v[4] = mk(8'h4C, 1'b0, 32'h0, 32'h0, 1'b1);
    err_v[5] = mk(8'h48, 1'b1, 32'h2, 32'h0, 1'b0);
    err_v[6] = mk(8'h4C, 1'b0, 32'h0, 32'h55, 1'b0);
    err_v[7] = mk(8'h4C, 1'b1, 32'h1, 32'h0, 1'b1);
    err_v[8] = mk(8'h02, 1'b0, 32'h0, 32'h0, 1'b1);
    err_v[9] = mk(8'h10, 1'b0, 32'h0, 32'h0, 1'b1);
    err_v[10] = mk(8'h50, 1'b1, 32'hDEAD, 32'h0, 1'b1);
    err_v[11] = mk(8'h00, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0);
    err_v[12] = mk(8'h00, 1'b0, 32'h0, 32'hFFFFF, 1'b0);
    err_v[13] = mk(8'h04, 1'b0, 32'h0, 32'hFFABC, 1'b0);
    err_v[14] = mk(8'h0C, 1'b0, 32'h0, 32'h9, 1'b0);
    err_v[15] = mk(8'h44, 1'b0, 32'h0, 32'h400, 1'b0);
    err_v[16] = mk(8'h40, 1'b0, 32'h0, 32'h0, 1'b0);
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE = 1'b0;
    bus.PADDR = '0;
    bus.PWDATA = '0;
    stb_h = '0;
    busy_h = '0;
    repeat (2) @(negedge clk);
    chk("rst_pready", 128'(bus.PREADY), 128'(0));
    chk("rst_pslverror", 128'(bus.PSLVERROR), 128'(0));
    chk("rst_prdata", 128'(bus.PRDATA), 128'(0));
    chk("rst_lcd", 128'({lcd_stb, lcd_busy, lcd_data}), 128'(0));
    resetn = 1'b1;
    @(negedge clk);
    foreach (init_v[i]) run_vec("init", init_v[i]);
    apb_wr(8'h00, 32'h123);
    apb_wr(8'h04, 32'hFFFFFABC);
    chk("lcd_before_commit", 128'(lcd_data), 128'(0));
    stb_h = '0;
    apb_wr(8'h40, 32'h1);
    chk("lcd_after_commit", 128'(lcd_data), 128'({20'h0, 20'h0, 20'hFFABC, 20'h00123}));
    repeat (13) tick;
    chk("stb_single_pulse", 128'(stb_h[16:0]), 128'({3'b0, {12{1'b1}}, 2'b0}));
    apb_rd(8'h44, 32'h100);
    stb_h = '0;
    busy_h = '0;
    apb_wr(8'h40, 32'h1);
    apb_wr(8'h08, 32'h55);
    apb_wr(8'h40, 32'h1);
    apb_wr(8'h40, 32'h1);
    repeat (13) tick;
    chk("stb_pending_pulses", 128'(stb_h[28:0]), 128'({3'b0, {12{1'b1}}, 1'b0, {12{1'b1}}, 1'b0}));
    chk("busy_pending_span", 128'(busy_h[28:0]), 128'({3'b0, {25{1'b1}}, 1'b0}));
    chk("lcd_deferred_copy", 128'(lcd_data), 128'({20'h0, 20'h55, 20'hFFABC, 20'h00123}));
    apb_rd(8'h44, 32'h300);
    apb_wr(8'h40, 32'h2);
    apb_rd(8'h40, 32'h2);
    apb_wr(8'h0C, 32'h7);
    chk("auto_stb_start", 128'(lcd_stb), 128'(1));
    chk("auto_lcd_ch3", 128'(lcd_data), 128'({20'h7, 20'h55, 20'hFFABC, 20'h00123}));
    repeat (12) tick;
    chk("auto_stb_end", 128'(lcd_stb), 128'(0));
    apb_wr(8'h40, 32'h0);
    apb_wr(8'h0C, 32'h9);
    chk("noauto_no_stb", 128'({lcd_stb, lcd_busy}), 128'(0));
    chk("noauto_lcd_hold", 128'(lcd_data), 128'({20'h7, 20'h55, 20'hFFABC, 20'h00123}));
    foreach (err_v[i]) run_vec("map", err_v[i]);
    chk("map_lcd_hold", 128'(lcd_data), 128'({20'h7, 20'h55, 20'hFFABC, 20'h00123}));
    apb_wr(8'h40, 32'h1);
    apb_wr(8'h40, 32'h1);
    chk("pre_reset_busy", 128'({lcd_stb, lcd_busy}), 128'(2'b11));
    resetn = 1'b0;
    #1;
    chk("async_rst_lcd", 128'({lcd_stb, lcd_busy, lcd_data}), 128'(0));
    chk("async_rst_pready", 128'({bus.PREADY, bus.PSLVERROR}), 128'(0));
    @(negedge clk);
    resetn = 1'b1;
    stb_h = '0;
    repeat (15) tick;
    chk("no_stb_after_reset", 128'(stb_h[14:0]), 128'(0));
    apb_rd(8'h44, 32'h0);
    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR = 16'h0000;
    bus.PWRITE = 1'b1;
    bus.PWDATA = 32'h777;
    tick;
    bus.PENABLE = 1'b1;
    tick;
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    tick;
    chk("abort_no_pready", 128'(bus.PREADY), 128'(0));
    tick;
    apb_rd(8'h00, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
